dieu_khien_cong_noi_tiep: RTL and testbench

//  Nibble-serial sequencer for one external 4-bit full-adder slice (A,B,C0 -> S,C4).

---
 rtl/dieu_khien_cong_noi_tiep_if.sv | 35 +++
 rtl/dieu_khien_cong_noi_tiep.sv | 140 ++++++++++++++
 tb/tb_dieu_khien_cong_noi_tiep.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dieu_khien_cong_noi_tiep_if.sv
// -----------------------------------------------------------------------------
// dieu_khien_cong_noi_tiep_if
// Host-side bus of the nibble-serial add sequencer.
//   start       host -> seq : operation request, looked at only while idle
//   a, b, cin   host -> seq : operands and carry-in, captured with an accepted start
//   sub         host -> seq : subtract select (only when SERIAL_SUB_EN is defined)
//   busy        seq -> host : operation in progress (RUN or DONE)
//   done        seq -> host : one-cycle pulse, sum/cout valid
//   sum, cout   seq -> host : result, held until the next accepted start
// Modports: master = host side, slave = sequencer side.
// Optional feature macro: SERIAL_SUB_EN.
// -----------------------------------------------------------------------------
interface dieu_khien_cong_noi_tiep_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/dieu_khien_cong_noi_tiep.sv
// -----------------------------------------------------------------------------
// dieu_khien_cong_noi_tiep
// Nibble-serial sequencer driving one external 4-bit full-adder slice.
// Adds two WIDTH-bit operands in WIDTH/4 steps, least-significant nibble first,
// rippling the carry through a local carry register. Contains no adder itself.
//
// Ports
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   host         : host bus (start/a/b/cin[/sub] in, busy/done/sum/cout out)
//   add_a, add_b : current nibble of the captured operands, to the slice
//   add_c0       : carry register, to the slice carry-in
//   add_s, add_c4: slice sum nibble and carry-out
//   dbg_state    : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a level sampled only in IDLE; when sampled high at a
// rising edge the operands are captured and busy rises. Starts seen while busy
// are dropped, never queued. done is a single-cycle pulse that appears NIBBLES
// edges after the accepting edge; sum/cout stay valid until the next accepted
// start. busy covers RUN and DONE.
//
// Optional feature macro: SERIAL_SUB_EN (adds host.sub; sub=1 computes a-b,
// cout=1 meaning no borrow).
// -----------------------------------------------------------------------------
module dieu_khien_cong_noi_tiep #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    dieu_khien_cong_noi_tiep_if.slave     host,
    output logic [3:0]                    add_a,
    output logic [3:0]                    add_b,
    output logic                          add_c0,
    input  logic [3:0]                    add_s,
    input  logic                          add_c4,
    output logic [1:0]                    dbg_state
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    a_d     = host.a;
`ifdef SERIAL_SUB_EN
                    // Subtraction as a + ~b + 1; the final carry is the no-borrow flag.
                    b_d     = host.sub ? ~host.b : host.b;
                    carry_d = host.sub ? 1'b1 : host.cin;
`else
                    b_d     = host.b;
                    carry_d = host.cin;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = add_s;
                carry_d = add_c4;
                if (idx_q == LAST_IDX) begin
                    // Wrap idx so it never leaves 0..NIBBLES-1 for any WIDTH.
                    idx_d   = '0;
                    cout_d  = add_c4;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Slice inputs are only meaningful in RUN; park them at zero otherwise.
    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_c0 = 1'b0;
        if (state_q == S_RUN) begin
            add_a  = a_q[{idx_q, 2'b00} +: 4];
            add_b  = b_q[{idx_q, 2'b00} +: 4];
            add_c0 = carry_q;
        end
    end

    assign host.busy = (state_q != S_IDLE);
    assign host.done = (state_q == S_DONE);
    assign host.sum  = sum_q;
    assign host.cout = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dieu_khien_cong_noi_tiep.sv
module tb_dieu_khien_cong_noi_tiep;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;  // 0: 16-bit instance, 1: 8-bit instance

  logic [16:0] exp_q[$];  // {cout, sum}

  // ---------------- DUTs and adder slice models ----------------
  dieu_khien_cong_noi_tiep_if #(.WIDTH(16)) h16 ();
  dieu_khien_cong_noi_tiep_if #(.WIDTH(8))  h8 ();

  logic [3:0] a16, b16, s16, a8, b8, s8;
  logic       c0_16, c4_16, c0_8, c4_8;
  logic [1:0] st16, st8;

  always_comb {c4_16, s16} = {1'b0, a16} + {1'b0, b16} + {4'b0, c0_16};
  always_comb {c4_8, s8}   = {1'b0, a8} + {1'b0, b8} + {4'b0, c0_8};

  dieu_khien_cong_noi_tiep #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .host(h16),
    .add_a(a16), .add_b(b16), .add_c0(c0_16),
    .add_s(s16), .add_c4(c4_16), .dbg_state(st16)
  );

  dieu_khien_cong_noi_tiep #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .host(h8),
    .add_a(a8), .add_b(b8), .add_c0(c0_8),
    .add_s(s8), .add_c4(c4_8), .dbg_state(st8)
  );

  // Observed signals of the selected instance
  logic        m_busy, m_done, m_cout, m_c0;
  logic [15:0] m_sum;
  logic [3:0]  m_add_a, m_add_b;
  logic [1:0]  m_state;
  always_comb begin
    m_busy  = sel ? h8.busy : h16.busy;
    m_done  = sel ? h8.done : h16.done;
    m_cout  = sel ? h8.cout : h16.cout;
    m_sum   = sel ? {8'h00, h8.sum} : h16.sum;
    m_add_a = sel ? a8 : a16;
    m_add_b = sel ? b8 : b16;
    m_c0    = sel ? c0_8 : c0_16;
    m_state = sel ? st8 : st16;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [16:0] ref_model(input int w, input logic [15:0] x, y,
                                            input logic c, input logic s);
    longint mask, xx, yy, total;
    mask  = (64'd1 << w) - 1;
    xx    = longint'(x) & mask;
    yy    = longint'(y) & mask;
    if (s) yy = yy ^ mask;
    total = xx + yy + ((s ? 1 : 0) + (s ? 0 : (c ? 1 : 0)));
    return {1'(total >> w), 16'(total & mask)};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit st, input logic [15:0] x, y, input logic c, input logic s);
    if (sel) begin
      h8.start = st; h8.a = x[7:0]; h8.b = y[7:0]; h8.cin = c;
`ifdef SERIAL_SUB_EN
      h8.sub = s;
`endif
    end else begin
      h16.start = st; h16.a = x; h16.b = y; h16.cin = c;
`ifdef SERIAL_SUB_EN
      h16.sub = s;
`endif
    end
    if (s && 1'b0) st = 1'b0;
  endtask

  // One full operation: start, step-by-step slice checks, latency, result, done width.
  task automatic run_op(input logic [15:0] op_a, op_b, input logic op_cin, op_sub,
                        input logic [15:0] exp_sum, input logic exp_cout, input bit poke);
    int cyc, busy_cnt, nib;
    logic [16:0] exp;
    logic [15:0] b_eff;
    logic        c_eff;
    nib = sel ? 2 : 4;
`ifdef SERIAL_SUB_EN
    b_eff = op_sub ? ~op_b : op_b;
    c_eff = op_sub ? 1'b1 : op_cin;
`else
    b_eff = op_b;
    c_eff = op_cin;
`endif
    exp_q.push_back({exp_cout, exp_sum});
    @(negedge clk);
    set_in(1'b1, op_a, op_b, op_cin, op_sub);
    @(posedge clk); #1;
    // Post-capture operand changes must not matter.
    set_in(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), op_sub);
    busy_cnt = 0;
    cyc = 0;
    while (cyc < 20) begin
      if (m_busy) busy_cnt++;
      if (m_done) break;
      if (cyc < nib) begin
        check("slice_a", 32'(m_add_a), 32'((op_a >> (4 * cyc)) & 16'hF));
        check("slice_b", 32'(m_add_b), 32'((b_eff >> (4 * cyc)) & 16'hF));
      end
      if (cyc == 0) check("slice_c0", 32'(m_c0), 32'(c_eff));
      @(negedge clk);
      if (poke && cyc == 0) set_in(1'b1, 16'h1111, 16'h1111, 1'b1, 1'b0);
      else begin
        if (sel) h8.start = 1'b0; else h16.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(nib));
    exp = exp_q.pop_front();
    check("sum", 32'(m_sum), 32'(exp[15:0]));
    check("cout", 32'(m_cout), 32'(exp[16]));
    check("busy_cycles", 32'(busy_cnt), 32'(nib + 1));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(m_done), 32'd0);
    check("busy_after", 32'(m_busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          w8;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};
    vecs[6] = '{1'b1, 16'h00A5, 16'h005B, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 16'h00FF, 16'h0000, 1'b1, 16'h0000, 1'b1};

    sel = 1'b0; set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    sel = 1'b1; set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    sel = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check("rst_busy", 32'(m_busy), 32'd0);
      check("rst_done", 32'(m_done), 32'd0);
      check("rst_sum", 32'(m_sum), 32'd0);
      check("rst_cout", 32'(m_cout), 32'd0);
      check("rst_state", 32'(m_state), 32'd0);
      check("rst_add_a", 32'(m_add_a), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      sel = vecs[i].w8;
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout, 1'b0);
    end

    // Start pulsed during RUN is ignored; the next start after DONE is accepted.
    sel = 1'b0;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Reset during RUN step 2 aborts the operation.
    begin
      int done_cnt;
      @(negedge clk);
      set_in(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_in(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      check("mid_sum_partial", 32'(m_sum), 32'h0055);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(m_busy), 32'd0);
      check("abort_done", 32'(m_done), 32'd0);
      check("abort_sum", 32'(m_sum), 32'd0);
      check("abort_cout", 32'(m_cout), 32'd0);
      check("abort_state", 32'(m_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (m_done) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0);
    end

`ifdef SERIAL_SUB_EN
    sel = 1'b0;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

    // Randomized operations against the reference model
    for (int n = 0; n < 1200; n++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [16:0] r;
      int          w;
      sel = (n >= 1000);
      w   = sel ? 8 : 16;
      ra  = 16'($urandom_range(0, (1 << w) - 1));
      rb  = 16'($urandom_range(0, (1 << w) - 1));
      rc  = 1'($urandom_range(0, 1));
`ifdef SERIAL_SUB_EN
      rs  = 1'($urandom_range(0, 1));
`else
      rs  = 1'b0;
`endif
      r = ref_model(w, ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, r[15:0], r[16], 1'b0);
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
